buffer_stream_ctrl: RTL and testbench
=====================================

// Module: buffer_stream_ctrl
// PURPOSE
//  Sequencer for the 32-bit-in / 64-bit-out operand buffer. Accepts one
//  tile of words from the loader (valid/ready), writes it into the buffer,
//  then streams it out as 64-bit word pairs to the systolic-array feeder.
//  Reads and writes are never issued to the buffer in the same cycle.
// PARAMETERS
//  DEPTH   16384  buffer capacity in 32-bit words
//  ADDR_W  14     buffer address width; bit ADDR_W-1 = read select
//  CNT_W   15     width of word/pair counters (holds DEPTH)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin tile, samples num_words
//  num_words    in   CNT_W   tile length in 32-bit words
//  wr_valid     in   1       loader word valid
//  wr_data      in   32      loader word
//  wr_ready     out  1       controller accepts loader word
//  buf_addr     out  ADDR_W  to buffer addr; MSB=1 issues a pair read
//  buf_we       out  1       to buffer write_enable
//  buf_wdata    out  32      to buffer data_in
//  buf_rdata    in   64      from buffer data_out
//  out_valid    out  1       pair valid to feeder
//  out_data     out  64      pair {older word, newer word}
//  out_ready    in   1       feeder accepts pair
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle pulse after last pair accepted
//  err          out  1       1-cycle pulse: start rejected
// BEHAVIOUR
//  - Reset: state=IDLE; all counters 0; every output 0 (buf_addr=0).
//  - All buffer-side outputs are registered. The idle command is
//    buf_we=0, buf_addr=0. buf_addr MSB is high for exactly 1 cycle per read.
//  - IDLE: wr_ready=0. start with num_words even, >=2 and <=DEPTH latches
//    num_words and goes to LOAD. Any other start value pulses err next
//    cycle and stays IDLE. start in a non-IDLE state is ignored.
//  - LOAD: wr_ready=1 while load_cnt<num_words. Each wr_valid&&wr_ready
//    registers buf_we=1, buf_addr=0, buf_wdata=wr_data for the next cycle.
//    load_cnt increments by 1. After the last write issues, wr_ready drops
//    and the state goes to SETTLE.
//  - SETTLE: 2 idle cycles so the buffer's registered empty flag updates
//    before the first read. Then go to STREAM.
//  - STREAM: keep at most 1 read in flight. Issue a read (buf_addr MSB=1)
//    only when no read is in flight and the output slot is empty, or the
//    slot is being consumed this cycle. A read issued in cycle t has
//    buf_rdata valid in t+1; it is captured into out_data with out_valid=1
//    at the t+1 edge.
//  - Output slot: out_data is held stable while out_valid && !out_ready.
//    It clears on handshake. pair_cnt increments on each handshake.
//  - pair_cnt==num_words/2 after a handshake -> DONE. Issued reads never
//    exceed num_words/2.
//  - DONE: done=1 for 1 cycle, busy=0 next cycle, state returns to IDLE.
//    The counters clear.
//  - reset_n low mid-tile: immediate return to IDLE, outputs 0, any
//    in-flight read is discarded. Buffer contents are not the controller's
//    concern.
//  - Width: counters are CNT_W bits and never wrap within a legal tile.
//    The num_words/2 compare uses num_words[CNT_W-1:1].
// TESTING
//  - Reset then start, num_words=4, words 1,2,3,4 with wr_valid held ->
//    4 writes on consecutive cycles, then pairs {1,2},{3,4}, done pulse,
//    busy=0.
//  - start with num_words=3, then 0, then DEPTH+1 -> err pulse each time,
//    wr_ready stays 0, no buffer command.
//  - STREAM with out_ready low 10 cycles -> out_data held; no 2nd read
//    issued (MSB stays 0); stream resumes when out_ready rises.
//  - Gappy wr_valid (1 every 3 cycles), num_words=8 -> exactly 8 buf_we
//    pulses, buf_addr MSB never high during LOAD/SETTLE.
//  - Assert reset_n low one cycle after the first read issues -> all
//    outputs 0 asynchronously. A new start with num_words=2 then completes
//    normally.
//  - num_words=DEPTH -> 16384 writes, 8192 pairs, no counter wrap; done
//    fires once.

Source files
------------

// File: rtl/buffer_stream_ctrl.sv
// Tile sequencer for the 32-bit-in / 64-bit-out operand buffer: loads one tile
// of words from the loader, waits for the buffer to settle, then streams word pairs out.
module buffer_stream_ctrl #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic [31:0]       buf_wdata,
    input  logic [63:0]       buf_rdata,
    output logic              out_valid,
    output logic [63:0]       out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] nw_q;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             settle_cnt;
    logic             rd_capture;
    logic             load_fire;
    logic             issue_rd;
    logic             out_fire;
    logic             start_ok;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] load_cnt_inc;
    logic [CNT_W-1:0] pair_cnt_inc;

    assign start_ok = (num_words[0] == 1'b0) && (num_words >= CNT_W'(2))
                      && (num_words <= CNT_W'(DEPTH));
    assign half         = {1'b0, nw_q[CNT_W-1:1]};
    assign load_cnt_inc = load_cnt + 1'b1;
    assign pair_cnt_inc = pair_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A read counts as in flight from the cycle its command is on buf_addr
    // until its data is captured one cycle later.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        load_fire  = 1'b0;
        issue_rd   = 1'b0;
        out_fire   = 1'b0;
        done       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start && start_ok) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_ready  = (load_cnt < nw_q);
                load_fire = wr_ready && wr_valid;
                if (load_fire && (load_cnt_inc == nw_q)) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt) begin
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                out_fire = out_valid && out_ready;
                issue_rd = !buf_addr[ADDR_W-1] && !rd_capture
                           && (!out_valid || out_fire) && (rd_cnt < half);
                if (out_fire && (pair_cnt_inc == half)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nw_q       <= '0;
            load_cnt   <= '0;
            pair_cnt   <= '0;
            rd_cnt     <= '0;
            settle_cnt <= 1'b0;
            rd_capture <= 1'b0;
            buf_addr   <= '0;
            buf_we     <= 1'b0;
            buf_wdata  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
        end else begin
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            err        <= 1'b0;
            rd_capture <= buf_addr[ADDR_W-1];
            settle_cnt <= (state == S_SETTLE) ? ~settle_cnt : 1'b0;
            if ((state == S_IDLE) && start) begin
                if (start_ok) begin
                    nw_q <= num_words;
                end else begin
                    err <= 1'b1;
                end
            end
            if (load_fire) begin
                buf_we    <= 1'b1;
                buf_wdata <= wr_data;
                load_cnt  <= load_cnt_inc;
            end
            if (issue_rd) begin
                buf_addr <= {1'b1, {(ADDR_W-1){1'b0}}};
                rd_cnt   <= rd_cnt + 1'b1;
            end
            if (out_fire) begin
                out_valid <= 1'b0;
                pair_cnt  <= pair_cnt_inc;
            end
            if (rd_capture) begin
                out_valid <= 1'b1;
                out_data  <= buf_rdata;
            end
            if (state == S_DONE) begin
                load_cnt <= '0;
                pair_cnt <= '0;
                rd_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_buffer_stream_ctrl.sv
// Bench for buffer_stream_ctrl: a FIFO-style buffer model answers pair reads,
// expected pairs are queued as the loader hands words over and checked as the feeder accepts them.
module tb_buffer_stream_ctrl;

    localparam int DEPTH  = 16384;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 15;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b1;
    logic              start     = 1'b0;
    logic [CNT_W-1:0]  num_words = '0;
    logic              wr_valid  = 1'b0;
    logic [31:0]       wr_data   = '0;
    logic              wr_ready;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_we;
    logic [31:0]       buf_wdata;
    logic [63:0]       buf_rdata = '0;
    logic              out_valid;
    logic [63:0]       out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int we_count, rd_count, done_count, pairs_rx, early_rd, extra_pairs, underflow;
    int first_we_cyc, last_we_cyc, cur_nw;

    logic [31:0] mem_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [63:0] ctl_outs;

    assign ctl_outs = {12'd0, wr_ready, buf_we, out_valid, busy, done, err, buf_addr, buf_wdata};

    buffer_stream_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_words (num_words),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .buf_addr  (buf_addr),
        .buf_we    (buf_we),
        .buf_wdata (buf_wdata),
        .buf_rdata (buf_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer model: words queue up in write order, a pair read returns the
    // two oldest words one cycle after the read command.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q.delete();
            buf_rdata <= '0;
        end else begin
            if (buf_we) mem_q.push_back(buf_wdata);
            if (buf_addr[ADDR_W-1]) begin
                if (mem_q.size() >= 2) begin
                    buf_rdata <= {mem_q[0], mem_q[1]};
                    void'(mem_q.pop_front());
                    void'(mem_q.pop_front());
                end else begin
                    underflow++;
                    buf_rdata <= '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (buf_we) begin
                we_count++;
                if (first_we_cyc < 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
            end
            if (buf_addr[ADDR_W-1]) begin
                rd_count++;
                if (we_count < cur_nw || cyc <= last_we_cyc + 2) early_rd++;
            end
            if (done) done_count++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    extra_pairs++;
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("pair", out_data, mon_exp);
                    pairs_rx++;
                end
            end
        end
    end

    task automatic clearCounters(input int nw);
        we_count     = 0;
        rd_count     = 0;
        done_count   = 0;
        pairs_rx     = 0;
        early_rd     = 0;
        extra_pairs  = 0;
        underflow    = 0;
        first_we_cyc = -1;
        last_we_cyc  = 0;
        cur_nw       = nw;
    endtask

    // Starts a tile and hands over nw words, idling gap cycles between words.
    task automatic applyStimulus(input int nw, input int gap, input logic [31:0] base);
        int          acc_count;
        bit          accepted;
        logic [31:0] w;
        logic [31:0] prev;
        acc_count = 0;
        prev      = '0;
        clearCounters(nw);
        start     = 1'b1;
        num_words = CNT_W'(nw);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            w        = base + 32'(i);
            wr_valid = 1'b1;
            wr_data  = w;
            accepted = 1'b0;
            for (int c = 0; c < 40 && !accepted; c++) begin
                @(negedge clk);
                accepted = wr_ready;
                @(posedge clk); #1;
            end
            if (!accepted) break;
            acc_count++;
            if (i % 2 == 1) exp_q.push_back({prev, w});
            prev     = w;
            wr_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        wr_valid = 1'b0;
        checkOutput("wr_accepts", 64'(acc_count), 64'(nw));
        @(negedge clk);
        checkOutput("wr_ready_after_load", 64'(wr_ready), 64'd0);
        checkOutput("busy_in_tile", 64'(busy), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drainTile(input int nw, input bit stall);
        bit          got;
        logic [63:0] head;
        if (stall) begin
            out_ready = 1'b0;
            got       = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            checkOutput("stall_first_valid", 64'(got), 64'd1);
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            for (int k = 0; k < 10; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_data", out_data, head);
                checkOutput("stall_no_read", 64'(buf_addr[ADDR_W-1]), 64'd0);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < nw * 2 + 100; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 64'(got), 64'd1);
        @(negedge clk);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("done_count", 64'(done_count), 64'd1);
        checkOutput("pairs_rx", 64'(pairs_rx), 64'(nw / 2));
        checkOutput("reads_issued", 64'(rd_count), 64'(nw / 2));
        checkOutput("writes_issued", 64'(we_count), 64'(nw));
        checkOutput("early_reads", 64'(early_rd), 64'd0);
        checkOutput("extra_pairs", 64'(extra_pairs), 64'd0);
        checkOutput("buf_underflow", 64'(underflow), 64'd0);
        checkOutput("exp_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int bad_nw[3];
        bit got;
        bad_nw = '{3, 0, DEPTH + 1};
        clearCounters(0);

        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_ctl", ctl_outs, 64'd0);
        checkOutput("reset_data", out_data, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic tile: four words with wr_valid held
        applyStimulus(4, 0, 32'd1);
        drainTile(4, 1'b0);
        checkOutput("we_consecutive", 64'(last_we_cyc - first_we_cyc), 64'd3);

        // Illegal tile lengths
        clearCounters(0);
        foreach (bad_nw[i]) begin
            start     = 1'b1;
            num_words = CNT_W'(bad_nw[i]);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checkOutput("err_pulse", 64'(err), 64'd1);
            checkOutput("err_wr_ready", 64'(wr_ready), 64'd0);
            checkOutput("err_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("err_clears", 64'(err), 64'd0);
            @(posedge clk); #1;
        end
        checkOutput("err_no_we", 64'(we_count), 64'd0);
        checkOutput("err_no_rd", 64'(rd_count), 64'd0);

        // Feeder back-pressure
        out_ready = 1'b0;
        applyStimulus(4, 0, 32'hA0);
        drainTile(4, 1'b1);

        // Gappy loader
        applyStimulus(8, 2, 32'hB0);
        drainTile(8, 1'b0);

        // Reset one cycle after the first read
        applyStimulus(4, 0, 32'hC0);
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (buf_addr[ADDR_W-1]) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("rd_issue_seen", 64'(got), 64'd1);
        checkOutput("busy_pre_reset", 64'(busy), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_ctl", ctl_outs, 64'd0);
        checkOutput("mid_reset_data", out_data, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(2, 0, 32'hD0);
        drainTile(2, 1'b0);

        // Full-depth tile
        applyStimulus(DEPTH, 0, 32'h1000_0000);
        drainTile(DEPTH, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
